// File: rtl/pin_pattern_rx.sv
// pin_pattern_rx
// Receives the slow LSB-first blink pattern from a remote pattern-blink block,
// recovers the bit timing from the pin edges and presents each complete frame
// (terminated by GAP_BITS zero bits) as a parallel word.
//
// Optional build macro: PIN_PATTERN_RX_GLITCH_FILTER_EN
//   defined   -> 3-sample majority filter after the synchronizer (4-cycle input
//                latency, single-cycle glitches ignored)
//   undefined -> raw 2-flop synchronizer output (2-cycle input latency)

module pin_pattern_rx #(
  parameter int BIT_CLKS = 2097152,  // clocks per bit, even and >= 8
  parameter int GAP_BITS = 5         // zero bits that terminate a frame
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        PIN_IN,
  output logic [31:0] WORD,
  output logic [5:0]  WORD_LEN,
  output logic        WORD_VALID,
  output logic        ERR,
  output logic        LED
);

  localparam int GAP_CLKS = GAP_BITS * BIT_CLKS;
  localparam int TMR_W    = $clog2(GAP_CLKS + 1);
  localparam int ZR_W     = $clog2(GAP_BITS + 1);

  localparam logic [TMR_W-1:0] GAP_LIM  = TMR_W'(GAP_CLKS);
  localparam logic [TMR_W-1:0] HALF_LD  = TMR_W'(BIT_CLKS / 2 - 1);
  localparam logic [TMR_W-1:0] BIT_LD   = TMR_W'(BIT_CLKS - 1);
  localparam logic [ZR_W-1:0]  ZR_LAST  = ZR_W'(GAP_BITS - 1);

  typedef enum logic [1:0] {
    S_ARM,   // waiting for a full idle gap before trusting any edge
    S_HUNT,  // gap seen, waiting for the frame's first rising edge
    S_RX     // receiving bits
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       s_in;
  logic       s_prev_q;

  // Two-flop synchronizer for the asynchronous pin.
  // NOTE: every asynchronous-reset register here uses non-blocking assignment so
  // all flops sample the same pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) sync_q <= '0;
    else          sync_q <= {sync_q[0], PIN_IN};
  end

`ifdef PIN_PATTERN_RX_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       filt_q;

  // Majority of the last three synchronized samples; a lone one-cycle pulse
  // never forms a majority and so never reaches the edge detector.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hist_q <= '0;
      filt_q <= 1'b0;
    end else begin
      hist_q <= {hist_q[0], sync_q[1]};
      filt_q <= (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) |
                (hist_q[0] & hist_q[1]);
    end
  end

  assign s_in = filt_q;
`else
  assign s_in = sync_q[1];
`endif

  // Previous conditioned level, for edge detection.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) s_prev_q <= 1'b0;
    else          s_prev_q <= s_in;
  end

  logic s_rise;
  logic s_edge;
  assign s_rise = s_in & ~s_prev_q;
  assign s_edge = s_in ^ s_prev_q;

  assign LED = s_in;

  // ---------------------------------------------------------------------------
  // Receive FSM and datapath
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;       // ARM: low-run count; RX: bit timer
  logic [5:0]        bit_idx_q, bit_idx_d;
  logic [ZR_W-1:0]   zero_run_q, zero_run_d;
  logic [4:0]        last_one_q, last_one_d;
  logic [31:0]       shift_q, shift_d;
  logic [31:0]       word_d;
  logic [5:0]        len_d;
  logic              valid_d;
  logic              err_d;
  logic [31:0]       keep_mask;

  // Bits 0..last_one of the shift register belong to the frame.
  assign keep_mask = 32'hFFFF_FFFF >> (5'd31 - last_one_q);

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_ARM;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      zero_run_q <= '0;
      last_one_q <= '0;
      shift_q    <= '0;
      WORD       <= '0;
      WORD_LEN   <= '0;
      WORD_VALID <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      zero_run_q <= zero_run_d;
      last_one_q <= last_one_d;
      shift_q    <= shift_d;
      WORD       <= word_d;
      WORD_LEN   <= len_d;
      WORD_VALID <= valid_d;
      ERR        <= err_d;
    end
  end

  // Next-state, bit timing, sampling and frame completion.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    timer_d    = timer_q;
    bit_idx_d  = bit_idx_q;
    zero_run_d = zero_run_q;
    last_one_d = last_one_q;
    shift_d    = shift_q;
    word_d     = WORD;
    len_d      = WORD_LEN;
    valid_d    = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      S_ARM: begin
        // Count a continuous low run; the count stops at the limit.
        if (s_in) begin
          timer_d = '0;
        end else if (timer_q == GAP_LIM) begin
          state_d = S_HUNT;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      S_HUNT: begin
        if (s_rise) begin
          state_d    = S_RX;
          timer_d    = HALF_LD;
          bit_idx_d  = '0;
          zero_run_d = '0;
          last_one_d = '0;
        end
      end

      S_RX: begin
        if (timer_q == '0) begin
          // Mid-bit sample.
          shift_d[bit_idx_q[4:0]] = s_in;
          bit_idx_d = bit_idx_q + 6'd1;
          timer_d   = BIT_LD;
          if (s_in) begin
            zero_run_d = '0;
            last_one_d = bit_idx_q[4:0];
          end else begin
            zero_run_d = zero_run_q + ZR_W'(1);
          end

          // Gap termination takes priority over overflow on the 32nd sample.
          if (!s_in && (zero_run_q == ZR_LAST)) begin
            word_d  = shift_q & keep_mask;
            len_d   = {1'b0, last_one_q} + 6'd1;
            valid_d = 1'b1;
            shift_d = '0;
            state_d = S_HUNT;
          end else if (bit_idx_q == 6'd31) begin
            err_d   = 1'b1;
            shift_d = '0;
            timer_d = '0;
            state_d = S_ARM;
          end
        end else if (s_edge) begin
          // Re-centre on the transmitter's bit boundary; no sample here.
          timer_d = HALF_LD;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end

      default: begin
        state_d = S_ARM;
        timer_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pin_pattern_rx.sv
// Self-checking bench for pin_pattern_rx with BIT_CLKS=16, GAP_BITS=5.
// Expected frames come from the transmitted patterns themselves: the word is
// the pattern and its length is the position of its highest set bit plus one.

module tb_pin_pattern_rx;

  localparam int BIT  = 16;
  localparam int GAP  = 5;
  localparam int HALF = BIT / 2;
`ifdef PIN_PATTERN_RX_GLITCH_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif
  localparam logic [63:0] PAT   = 64'h0000_0000_0547_7715;
  localparam logic [63:0] ALT33 = 64'h0000_0001_5555_5555;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        PIN_IN;
  logic [31:0] WORD;
  logic [5:0]  WORD_LEN;
  logic        WORD_VALID;
  logic        ERR;
  logic        LED;

  pin_pattern_rx #(.BIT_CLKS(BIT), .GAP_BITS(GAP)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .PIN_IN     (PIN_IN),
    .WORD       (WORD),
    .WORD_LEN   (WORD_LEN),
    .WORD_VALID (WORD_VALID),
    .ERR        (ERR),
    .LED        (LED)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] word;
    logic [5:0]  len;
    int unsigned at;
  } frame_t;

  frame_t      got_q[$];
  int          err_seen = 0;
  int unsigned err_at   = 0;
  int          vectors     = 0;
  int          miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled away from the active edge.
  always @(negedge CLK) begin
    if (WORD_VALID) got_q.push_back('{WORD, WORD_LEN, cyc});
    if (ERR) begin
      err_seen++;
      err_at = cyc;
    end
    if (WORD_VALID || ERR) check("pulse_excl", 64'(WORD_VALID & ERR), 64'd0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [63:0] bits, input int n, input int period);
    for (int i = 0; i < n; i++) begin
      PIN_IN = bits[i];
      tick(period);
    end
  endtask

  task automatic idle(input int n);
    PIN_IN = 1'b0;
    tick(n);
  endtask

  function automatic int model_len(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) if (w[i]) return i + 1;
    return 0;
  endfunction

  task automatic expect_frame(input string tag, input logic [31:0] w);
    frame_t f;
    check({tag, "_count"}, 64'(got_q.size()), 64'd1);
    if (got_q.size() > 0) begin
      f = got_q.pop_front();
      check({tag, "_word"}, 64'(f.word), 64'(w));
      check({tag, "_len"}, 64'(f.len), 64'(model_len(w)));
    end
    got_q.delete();
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    tick(3);
    RESET_N = 1'b1;
    tick(1);
  endtask

  // Random frame: starts and ends with a 1, never contains GAP zeros in a row.
  function automatic logic [31:0] rand_pattern();
    int          len;
    int          run;
    logic [31:0] w;
    logic        b;
    len = $urandom_range(1, 32 - GAP);
    w   = '0;
    run = 0;
    for (int i = 0; i < len; i++) begin
      b = (i == 0 || i == len - 1) ? 1'b1 : 1'($urandom % 2);
      if (run == GAP - 1) b = 1'b1;
      w[i] = b;
      run  = b ? 0 : run + 1;
    end
    return w;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int unsigned start;
    int          errs_before;
    logic [31:0] w;
    frame_t      f0, f1, f2;

    PIN_IN  = 1'b0;
    RESET_N = 1'b0;
    tick(2);

    // Reset values.
    check("rst_word", 64'(WORD), 64'd0);
    check("rst_len", 64'(WORD_LEN), 64'd0);
    check("rst_valid", 64'(WORD_VALID), 64'd0);
    check("rst_err", 64'(ERR), 64'd0);
    check("rst_led", 64'(LED), 64'd0);
    RESET_N = 1'b1;

    // Clean frame with exact output timing.
    idle(90);
    start = cyc;
    send(PAT, 27 + GAP, BIT);
    idle(20);
    check("clean_at", 64'(got_q.size() > 0 ? got_q[0].at : 0),
          64'(start + LAT + HALF + BIT * 31 + 1));
    expect_frame("clean", PAT[31:0]);
    check("clean_err", 64'(err_seen), 64'd0);

    // Continuous repeat: one pulse per 32-bit frame.
    start = cyc;
    for (int k = 0; k < 3; k++) send(PAT, 32, BIT);
    idle(20);
    check("rep_count", 64'(got_q.size()), 64'd3);
    if (got_q.size() == 3) begin
      f0 = got_q[0]; f1 = got_q[1]; f2 = got_q[2];
      check("rep_at0", 64'(f0.at), 64'(start + LAT + HALF + BIT * 31 + 1));
      check("rep_period1", 64'(f1.at - f0.at), 64'd512);
      check("rep_period2", 64'(f2.at - f1.at), 64'd512);
      check("rep_word0", 64'(f0.word), 64'(PAT[31:0]));
      check("rep_word2", 64'(f2.word), 64'(PAT[31:0]));
      check("rep_len1", 64'(f1.len), 64'd27);
    end
    got_q.delete();

    // Randomized frames.
    for (int k = 0; k < 12; k++) begin
      w = rand_pattern();
      send({32'd0, w}, model_len(w) + GAP, BIT);
      idle(4 + $urandom_range(0, 20));
      expect_frame($sformatf("rand%0d", k), w);
    end

    // Overflow: 33 alternating bits with no gap.
    w = PAT[31:0];
    send(PAT, 27 + GAP, BIT);
    idle(10);
    got_q.delete();
    errs_before = err_seen;
    start = cyc;
    send(ALT33, 33, BIT);
    idle(10);
    check("ovf_err_count", 64'(err_seen - errs_before), 64'd1);
    check("ovf_err_at", 64'(err_at), 64'(start + LAT + HALF + BIT * 31 + 1));
    check("ovf_no_valid", 64'(got_q.size()), 64'd0);
    check("ovf_word_kept", 64'(WORD), 64'(w));
    // Back in ARM: a frame without a preceding full gap is ignored.
    idle(20);
    send(PAT, 27, BIT);
    idle(30);
    check("ovf_arm_ignore", 64'(got_q.size()), 64'd0);
    idle(90);
    send(PAT, 27 + GAP, BIT);
    idle(10);
    expect_frame("ovf_recover", PAT[31:0]);

    // No preceding gap after reset.
    do_reset();
    send(PAT, 27, BIT);
    send(PAT, 27, BIT);
    check("nogap_ignore", 64'(got_q.size()), 64'd0);
    send(64'd0, GAP, BIT);
    idle(10);
    check("nogap_tail_ignore", 64'(got_q.size()), 64'd0);
    send(PAT, 27 + GAP, BIT);
    idle(10);
    expect_frame("nogap_first", PAT[31:0]);

    // Drift tolerance.
    send(PAT, 27 + GAP, 15);
    idle(20);
    expect_frame("drift15", PAT[31:0]);
    w = rand_pattern();
    send({32'd0, w}, model_len(w) + GAP, 17);
    idle(20);
    expect_frame("drift17", w);

    // Reset mid-frame, while the input is high.
    send(PAT, 4, BIT);
    PIN_IN = 1'b1;
    tick(8);
    #2 RESET_N = 1'b0;
    #1;
    check("midrst_word", 64'(WORD), 64'd0);
    check("midrst_len", 64'(WORD_LEN), 64'd0);
    check("midrst_led", 64'(LED), 64'd0);
    check("midrst_valid", 64'(WORD_VALID), 64'd0);
    tick(3);
    RESET_N = 1'b1;
    tick(5);
    send(PAT >> 5, 22, BIT);
    idle(30);
    check("midrst_no_pulse", 64'(got_q.size()), 64'd0);
    idle(90);
    send(PAT, 27 + GAP, BIT);
    idle(10);
    expect_frame("midrst_recover", PAT[31:0]);

`ifdef PIN_PATTERN_RX_GLITCH_FILTER_EN
    // One-cycle glitch during the gap must not start a frame.
    idle(30);
    PIN_IN = 1'b1;
    tick(1);
    idle(GAP * BIT + 40);
    check("glitch_no_frame", 64'(got_q.size()), 64'd0);
    send(PAT, 27 + GAP, BIT);
    idle(10);
    expect_frame("glitch_after", PAT[31:0]);
`endif

    check("total_err", 64'(err_seen), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
